// File: rtl/cm163_down_counter_slice_if.sv
// rtl/cm163_down_counter_slice_if.sv - control/data bundle of one cascadable down-counter slice
interface cm163_down_counter_slice_if #(
    parameter int WIDTH = 4
);
    logic             ld_n_pad;
    logic             en_p_pad;
    logic             en_t_pad;
    logic [WIDTH-1:0] d_pad;
    logic [WIDTH-1:0] q_pad;
    logic             bo_pad;
    logic             uf_pad;
    logic             busy_pad;

    modport master (
        output ld_n_pad, en_p_pad, en_t_pad, d_pad,
        input  q_pad, bo_pad, uf_pad, busy_pad
    );

    modport slave (
        input  ld_n_pad, en_p_pad, en_t_pad, d_pad,
        output q_pad, bo_pad, uf_pad, busy_pad
    );
endinterface

// File: rtl/cm163_down_counter_slice.sv
// rtl/cm163_down_counter_slice.sv - loadable synchronous down-counter slice with borrow lookahead
module cm163_down_counter_slice #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic                   clk_pad,
    input  logic                   rst_n_pad,
    cm163_down_counter_slice_if.slave cnt
);
    localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             uf_r;
    logic             uf_next;
    logic             busy_r;
    logic             zero;
    logic             count_en;

    assign zero     = (q_r == '0);
    assign count_en = cnt.ld_n_pad & cnt.en_p_pad & cnt.en_t_pad;

    always_comb begin
        q_next  = q_r;
        uf_next = 1'b0;
        if (!cnt.ld_n_pad) begin
            q_next = cnt.d_pad;
        end else if (count_en) begin
            q_next  = q_r - ONE;
            uf_next = zero;
        end
    end

    // busy is registered from the next value so it never glitches with q.
    always_ff @(posedge clk_pad) begin
        if (!rst_n_pad) begin
            q_r    <= RESET_Q;
            uf_r   <= 1'b0;
            busy_r <= (RESET_Q != '0);
        end else begin
            q_r    <= q_next;
            uf_r   <= uf_next;
            busy_r <= (q_next != '0);
        end
    end

    // Borrow lookahead ignores en_p and ld_n so a chain settles without rippling through P.
    assign cnt.bo_pad   = cnt.en_t_pad & zero;
    assign cnt.q_pad    = q_r;
    assign cnt.uf_pad   = uf_r;
    assign cnt.busy_pad = busy_r;
endmodule

// File: tb/tb_cm163_down_counter_slice.sv
// tb/tb_cm163_down_counter_slice.sv - scoreboard bench for a two-slice cascaded down-counter
module tb_cm163_down_counter_slice;
    logic clk = 1'b0;
    logic rst_n;
    logic ld_n;
    logic en_p;
    logic en_t;
    logic [7:0] d;

    always #5 clk = ~clk;

    cm163_down_counter_slice_if #(.WIDTH(4)) lo_if ();
    cm163_down_counter_slice_if #(.WIDTH(4)) hi_if ();

    assign lo_if.ld_n_pad = ld_n;
    assign lo_if.en_p_pad = en_p;
    assign lo_if.en_t_pad = en_t;
    assign lo_if.d_pad    = d[3:0];
    assign hi_if.ld_n_pad = ld_n;
    assign hi_if.en_p_pad = en_p;
    assign hi_if.en_t_pad = lo_if.bo_pad;
    assign hi_if.d_pad    = d[7:4];

    cm163_down_counter_slice #(.WIDTH(4), .RESET_VAL(0)) u_lo (
        .clk_pad(clk), .rst_n_pad(rst_n), .cnt(lo_if.slave));
    cm163_down_counter_slice #(.WIDTH(4), .RESET_VAL(0)) u_hi (
        .clk_pad(clk), .rst_n_pad(rst_n), .cnt(hi_if.slave));

    typedef struct {
        logic [7:0] q;
        logic       uf_lo, uf_hi, busy_lo, busy_hi, bo_lo, bo_hi;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: the pair is one 8-bit modulo-256 down-counter.
    logic [7:0] v = 8'h00;
    logic       m_uf_lo = 1'b0;
    logic       m_uf_hi = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic p, input logic t, input logic [7:0] dv);
        exp_t e;
        @(negedge clk);
        rst_n = r; ld_n = l; en_p = p; en_t = t; d = dv;
        if (!r) begin
            v = 8'h00; m_uf_lo = 1'b0; m_uf_hi = 1'b0;
        end else if (!l) begin
            v = dv; m_uf_lo = 1'b0; m_uf_hi = 1'b0;
        end else if (p && t) begin
            m_uf_lo = (v[3:0] == 4'h0);
            m_uf_hi = (v == 8'h00);
            v = v - 8'd1;
        end else begin
            m_uf_lo = 1'b0; m_uf_hi = 1'b0;
        end
        e.q       = v;
        e.uf_lo   = m_uf_lo;
        e.uf_hi   = m_uf_hi;
        e.busy_lo = (v[3:0] != 4'h0);
        e.busy_hi = (v[7:4] != 4'h0);
        e.bo_lo   = t && (v[3:0] == 4'h0);
        e.bo_hi   = t && (v == 8'h00);
        sbq.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("q",       {hi_if.q_pad, lo_if.q_pad}, e.q);
            chk("uf_lo",   {7'd0, lo_if.uf_pad},   {7'd0, e.uf_lo});
            chk("uf_hi",   {7'd0, hi_if.uf_pad},   {7'd0, e.uf_hi});
            chk("busy_lo", {7'd0, lo_if.busy_pad}, {7'd0, e.busy_lo});
            chk("busy_hi", {7'd0, hi_if.busy_pad}, {7'd0, e.busy_hi});
            chk("bo_lo",   {7'd0, lo_if.bo_pad},   {7'd0, e.bo_lo});
            chk("bo_hi",   {7'd0, hi_if.bo_pad},   {7'd0, e.bo_hi});
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0; ld_n = 1'b1; en_p = 1'b0; en_t = 1'b0; d = 8'h00;
        // reset, then bo with en_t high
        step(0, 1, 0, 1, 8'h00);
        step(1, 1, 0, 1, 8'h00);
        // load 5 and count to zero
        step(1, 0, 0, 0, 8'h05);
        repeat (5) step(1, 1, 1, 1, 8'h00);
        // wrap from zero, then one more
        step(1, 1, 1, 1, 8'h00);
        step(1, 1, 1, 1, 8'h00);
        // load wins over enables, then hold
        step(1, 0, 1, 1, 8'h09);
        repeat (3) step(1, 1, 0, 1, 8'h00);
        step(1, 1, 1, 0, 8'h00);
        // cascade across the slice boundary and full wrap
        step(1, 0, 0, 0, 8'h10);
        repeat (17) step(1, 1, 1, 1, 8'h00);
        // mid-count reset overrides load
        step(1, 0, 0, 0, 8'h07);
        step(0, 0, 1, 1, 8'h03);
        // load zero then count
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 1, 8'h00);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom));
        end
        budget = 10;
        while (sbq.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
